// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer
//   Upstream control stage for the 8-entry register file (R1-R4 = index 0-3,
//   S1-S4 = index 4-7). Accepts one register-transfer command per valid/ready
//   handshake and drives the file's I, FunSel, RegSel, ScrSel, OutASel and
//   OutBSel for one or more cycles. Owns the I-input mux (command immediate
//   vs. OutA feedback). Ops: LDI, MOV, INC, DEC, CLR and a 3-cycle SWAP that
//   goes through the TEMP_SEL scratch register.
//
// Ports
//   Clock     rising-edge clock
//   Reset     asynchronous active-low reset
//   CmdValid  / CmdReady        command handshake (CmdReady only in IDLE)
//   CmdOp, CmdDst, CmdSrc, CmdImm  command fields, latched on accept
//   RfOutA    register file OutA feedback
//   I, FunSel, RegSel, ScrSel, OutASel, OutBSel   register file control
//   Done      one-cycle completion pulse; Err qualifies Done (rejected cmd)
//   CmdCount  completed-command counter
//
// Optional feature: define RF_SEQ_CMDCOUNT_EN to build the saturating
// completed-command counter; otherwise CmdCount is tied to zero.
//
// All control outputs decode combinationally from the state register and the
// latched command so that asserting Reset removes every write enable at once.

module rf_op_sequencer #(
    parameter logic [2:0]  TEMP_SEL = 3'd7,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [2:0]       CmdOp,
    input  logic [2:0]       CmdDst,
    input  logic [2:0]       CmdSrc,
    input  logic [15:0]      CmdImm,
    input  logic [15:0]      RfOutA,
    output logic [15:0]      I,
    output logic [2:0]       FunSel,
    output logic [3:0]       RegSel,
    output logic [3:0]       ScrSel,
    output logic [2:0]       OutASel,
    output logic [2:0]       OutBSel,
    output logic             Done,
    output logic             Err,
    output logic [CNT_W-1:0] CmdCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR1,
        S_WR2,
        S_WR3,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_LDI  = 3'b000,
        OP_MOV  = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_CLR  = 3'b100,
        OP_SWAP = 3'b101,
        OP_IL6  = 3'b110,
        OP_IL7  = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        F_DEC  = 3'b000,
        F_INC  = 3'b001,
        F_LOAD = 3'b010,
        F_CLR  = 3'b011
    } fun_t;

    typedef enum logic [1:0] {
        I_ZERO,
        I_IMM,
        I_FB
    } isel_t;

    state_t      state;
    op_t         op_q;
    logic [2:0]  dst_q;
    logic [2:0]  src_q;
    logic [15:0] imm_q;
    logic        err_q;

    logic        cmd_illegal;
    logic        wr_en;
    logic [2:0]  wr_idx;
    fun_t        fun;
    isel_t       i_sel;
    logic [2:0]  outa_sel;

    // A SWAP naming the scratch register would clobber its own operand.
    assign cmd_illegal = (CmdOp == OP_IL6) || (CmdOp == OP_IL7) ||
                         ((CmdOp == OP_SWAP) &&
                          ((CmdDst == TEMP_SEL) || (CmdSrc == TEMP_SEL)));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            op_q  <= OP_LDI;
            dst_q <= '0;
            src_q <= '0;
            imm_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (CmdValid) begin
                        op_q  <= op_t'(CmdOp);
                        dst_q <= CmdDst;
                        src_q <= CmdSrc;
                        imm_q <= CmdImm;
                        err_q <= cmd_illegal;
                        state <= cmd_illegal ? S_DONE : S_WR1;
                    end
                end
                S_WR1:   state <= (op_q == OP_SWAP) ? S_WR2 : S_DONE;
                S_WR2:   state <= S_WR3;
                S_WR3:   state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = '0;
        fun      = F_DEC;
        i_sel    = I_ZERO;
        outa_sel = '0;
        case (state)
            S_WR1: begin
                case (op_q)
                    OP_LDI: begin
                        wr_en = 1'b1; wr_idx = dst_q; fun = F_LOAD; i_sel = I_IMM;
                    end
                    OP_MOV: begin
                        wr_en = 1'b1; wr_idx = dst_q; fun = F_LOAD; i_sel = I_FB;
                        outa_sel = src_q;
                    end
                    OP_INC: begin
                        wr_en = 1'b1; wr_idx = dst_q; fun = F_INC;
                    end
                    OP_DEC: begin
                        wr_en = 1'b1; wr_idx = dst_q; fun = F_DEC;
                    end
                    OP_CLR: begin
                        wr_en = 1'b1; wr_idx = dst_q; fun = F_CLR;
                    end
                    OP_SWAP: begin
                        wr_en = 1'b1; wr_idx = TEMP_SEL; fun = F_LOAD; i_sel = I_FB;
                        outa_sel = dst_q;
                    end
                    default: ;
                endcase
            end
            S_WR2: begin
                wr_en = 1'b1; wr_idx = dst_q; fun = F_LOAD; i_sel = I_FB;
                outa_sel = src_q;
            end
            S_WR3: begin
                wr_en = 1'b1; wr_idx = src_q; fun = F_LOAD; i_sel = I_FB;
                outa_sel = TEMP_SEL;
            end
            default: ;
        endcase
    end

    // Enable bit for index d is 3-d within its bank, i.e. the inverted low bits.
    always_comb begin
        RegSel = '1;
        ScrSel = '1;
        if (wr_en) begin
            if (!wr_idx[2]) RegSel[~wr_idx[1:0]] = 1'b0;
            else            ScrSel[~wr_idx[1:0]] = 1'b0;
        end
    end

    always_comb begin
        case (i_sel)
            I_IMM:   I = imm_q;
            I_FB:    I = RfOutA;
            default: I = '0;
        endcase
    end

    assign FunSel   = fun;
    assign OutASel  = outa_sel;
    assign OutBSel  = (state == S_IDLE) ? 3'b000 : src_q;
    assign CmdReady = (state == S_IDLE);
    assign Done     = (state == S_DONE);
    assign Err      = (state == S_DONE) && err_q;

`ifdef RF_SEQ_CMDCOUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else if ((state == S_DONE) && !err_q && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign CmdCount = cnt_q;
`else
    assign CmdCount = '0;
`endif

endmodule

// File: tb/tb_rf_op_sequencer.sv
module tb_rf_op_sequencer;

    localparam logic [2:0] T = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        CmdValid;
    logic        CmdReady;
    logic [2:0]  CmdOp, CmdDst, CmdSrc;
    logic [15:0] CmdImm;
    logic [15:0] RfOutA;
    logic [15:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel, ScrSel;
    logic [2:0]  OutASel, OutBSel;
    logic        Done, Err;
    logic [15:0] CmdCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_op_sequencer #(.TEMP_SEL(3'd7), .CNT_W(16)) dut (
        .Clock(clk), .Reset(rst_n), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdOp(CmdOp), .CmdDst(CmdDst), .CmdSrc(CmdSrc), .CmdImm(CmdImm),
        .RfOutA(RfOutA), .I(I), .FunSel(FunSel), .RegSel(RegSel), .ScrSel(ScrSel),
        .OutASel(OutASel), .OutBSel(OutBSel), .Done(Done), .Err(Err),
        .CmdCount(CmdCount)
    );

    // Behavioural register file the sequencer drives.
    logic [15:0] rf [8] = '{default: 16'h0000};

    function automatic logic [15:0] rf_next(input logic [15:0] old, input logic [2:0] f,
                                            input logic [15:0] d);
        case (f)
            3'b000:  return old - 16'd1;
            3'b001:  return old + 16'd1;
            3'b010:  return d;
            3'b011:  return 16'h0000;
            default: return old;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!RegSel[k]) rf[3-k] <= rf_next(rf[3-k], FunSel, I);
            if (!ScrSel[k]) rf[7-k] <= rf_next(rf[7-k], FunSel, I);
        end
    end

    assign RfOutA = rf[OutASel];

    // Reference model: architectural register contents and expected behaviour.
    logic [15:0] ref_rf [8];
    logic [87:0] exp_tr;
    int          exp_nw, exp_lat;
    logic        exp_err;
    logic [15:0] exp_count;

    logic [87:0] obs_tr;
    int          obs_nw, obs_lat;
    logic        obs_err, obs_stray;
    logic [2:0]  obs_outb;

    task automatic add_wr(input int idx, input logic [2:0] f, input logic [15:0] dat);
        if (exp_nw < 4) exp_tr[22*exp_nw +: 22] = {3'(idx), f, (f == 3'b010) ? dat : 16'h0000};
        exp_nw++;
    endtask

    task automatic model(input logic [2:0] op, d, s, input logic [15:0] imm);
        logic [15:0] t;
        exp_tr = '0;
        exp_nw = 0;
        if (op > 3'd5 || (op == 3'd5 && (d == T || s == T))) begin
            exp_err = 1'b1;
            exp_lat = 1;
        end else begin
            exp_err = 1'b0;
            exp_lat = (op == 3'd5) ? 4 : 2;
            case (op)
                3'd0: begin add_wr(d, 3'b010, imm);       ref_rf[d] = imm; end
                3'd1: begin add_wr(d, 3'b010, ref_rf[s]); ref_rf[d] = ref_rf[s]; end
                3'd2: begin add_wr(d, 3'b001, 16'h0);     ref_rf[d] = ref_rf[d] + 16'd1; end
                3'd3: begin add_wr(d, 3'b000, 16'h0);     ref_rf[d] = ref_rf[d] - 16'd1; end
                3'd4: begin add_wr(d, 3'b011, 16'h0);     ref_rf[d] = 16'h0000; end
                default: begin
                    t = ref_rf[d];
                    add_wr(T, 3'b010, t);         ref_rf[T] = t;
                    add_wr(d, 3'b010, ref_rf[s]); ref_rf[d] = ref_rf[s];
                    add_wr(s, 3'b010, ref_rf[T]); ref_rf[s] = ref_rf[T];
                end
            endcase
            if (exp_count != 16'hFFFF) exp_count++;
        end
    endtask

    function automatic logic [127:0] rf_snap();
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[16*k +: 16] = rf[k];
        return v;
    endfunction

    function automatic logic [127:0] ref_snap();
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[16*k +: 16] = ref_rf[k];
        return v;
    endfunction

    // Drives one command and records what the sequencer does until Done.
    task automatic send(input logic [2:0] op, d, s, input logic [15:0] imm);
        int t, cnt, idx;
        obs_tr = '0; obs_nw = 0; obs_lat = 0; obs_err = 1'b0; obs_stray = 1'b0;
        @(negedge clk);
        CmdValid = 1'b1; CmdOp = op; CmdDst = d; CmdSrc = s; CmdImm = imm;
        t = 0;
        while (!CmdReady && t < 20) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 CmdValid = 1'b0;
        @(negedge clk);
        obs_outb = OutBSel;
        for (int n = 0; n < 10; n++) begin
            cnt = 0; idx = 0;
            for (int k = 0; k < 4; k++) begin
                if (!RegSel[k]) begin cnt++; idx = 3 - k; end
                if (!ScrSel[k]) begin cnt++; idx = 7 - k; end
            end
            if (cnt > 1 || CmdReady || (Err && !Done)) obs_stray = 1'b1;
            if (cnt == 1) begin
                if (obs_nw < 4)
                    obs_tr[22*obs_nw +: 22] = {3'(idx), FunSel, (FunSel == 3'b010) ? I : 16'h0000};
                obs_nw++;
            end
            if (Done) begin obs_lat = n + 1; obs_err = Err; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; CmdValid = 1'b0; CmdOp = '0; CmdDst = '0; CmdSrc = '0; CmdImm = '0;
        for (int k = 0; k < 8; k++) ref_rf[k] = 16'h0000;
        exp_count = '0;
        #3;
        checks++;
        if ({RegSel, ScrSel, FunSel, I, OutASel, OutBSel, CmdReady, Done, Err} !==
            {4'hF, 4'hF, 3'b000, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h %h %b %h %b %b rdy=%b done=%b err=%b",
                     RegSel, ScrSel, FunSel, I, OutASel, OutBSel, CmdReady, Done, Err);
        end
        checks++;
        if (CmdCount !== 16'h0000) begin
            errors++; $display("FAIL reset_count: got %h want 0000", CmdCount);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ldi();
        model(3'd0, 3'd2, 3'd0, 16'hA5C3);
        send(3'd0, 3'd2, 3'd0, 16'hA5C3);
        checks++;
        if ({obs_nw, obs_tr} !== {exp_nw, exp_tr}) begin
            errors++; $display("FAIL ldi_writes: got %0d/%h want %0d/%h", obs_nw, obs_tr, exp_nw, exp_tr);
        end
        checks++;
        if (obs_lat !== 2 || obs_err !== 1'b0) begin
            errors++; $display("FAIL ldi_done: got lat=%0d err=%b want lat=2 err=0", obs_lat, obs_err);
        end
        checks++;
        if (rf[2] !== 16'hA5C3) begin
            errors++; $display("FAIL ldi_readback: got %h want a5c3", rf[2]);
        end
        // MOV onto itself reloads its own value.
        model(3'd1, 3'd2, 3'd2, 16'h0);
        send(3'd1, 3'd2, 3'd2, 16'h0);
        checks++;
        if ({obs_nw, obs_tr, obs_lat} !== {exp_nw, exp_tr, exp_lat} || rf_snap() !== ref_snap()) begin
            errors++; $display("FAIL mov_self: got %0d/%h lat=%0d r3=%h want %0d/%h lat=%0d r3=%h",
                               obs_nw, obs_tr, obs_lat, rf[2], exp_nw, exp_tr, exp_lat, ref_rf[2]);
        end
    endtask

    task automatic test_inc_wrap();
        model(3'd0, 3'd0, 3'd0, 16'hFFFF);
        send(3'd0, 3'd0, 3'd0, 16'hFFFF);
        model(3'd2, 3'd0, 3'd0, 16'h0);
        send(3'd2, 3'd0, 3'd0, 16'h0);
        checks++;
        if ({obs_nw, obs_tr} !== {exp_nw, exp_tr}) begin
            errors++; $display("FAIL inc_writes: got %0d/%h want %0d/%h", obs_nw, obs_tr, exp_nw, exp_tr);
        end
        checks++;
        if (rf[0] !== 16'h0000 || obs_lat !== 2 || obs_err !== 1'b0) begin
            errors++; $display("FAIL inc_wrap: got r1=%h lat=%0d err=%b want r1=0000 lat=2 err=0",
                               rf[0], obs_lat, obs_err);
        end
    endtask

    task automatic test_swap();
        model(3'd0, 3'd0, 3'd0, 16'h1234); send(3'd0, 3'd0, 3'd0, 16'h1234);
        model(3'd0, 3'd1, 3'd0, 16'h5678); send(3'd0, 3'd1, 3'd0, 16'h5678);
        model(3'd5, 3'd0, 3'd1, 16'h0);    send(3'd5, 3'd0, 3'd1, 16'h0);
        checks++;
        if ({obs_nw, obs_tr} !== {exp_nw, exp_tr}) begin
            errors++; $display("FAIL swap_writes: got %0d/%h want %0d/%h", obs_nw, obs_tr, exp_nw, exp_tr);
        end
        checks++;
        if ({rf[0], rf[1], rf[7]} !== {16'h5678, 16'h1234, 16'h1234}) begin
            errors++; $display("FAIL swap_result: got %h %h %h want 5678 1234 1234", rf[0], rf[1], rf[7]);
        end
        checks++;
        if (obs_lat !== 4 || obs_err !== 1'b0 || obs_stray !== 1'b0) begin
            errors++; $display("FAIL swap_done: got lat=%0d err=%b stray=%b want 4 0 0", obs_lat, obs_err, obs_stray);
        end
        model(3'd5, 3'd2, 3'd2, 16'h0); send(3'd5, 3'd2, 3'd2, 16'h0);
        checks++;
        if ({obs_nw, obs_tr, obs_lat} !== {exp_nw, exp_tr, exp_lat} || rf_snap() !== ref_snap()) begin
            errors++; $display("FAIL swap_same: got %0d lat=%0d want %0d lat=%0d", obs_nw, obs_lat, exp_nw, exp_lat);
        end
    endtask

    task automatic test_illegal();
        logic [8:0] cmds [4];
        cmds[0] = {3'd5, 3'd7, 3'd1};
        cmds[1] = {3'd5, 3'd1, 3'd7};
        cmds[2] = {3'd6, 3'd2, 3'd3};
        cmds[3] = {3'd7, 3'd4, 3'd5};
        for (int c = 0; c < 4; c++) begin
            model(cmds[c][8:6], cmds[c][5:3], cmds[c][2:0], 16'hBEEF);
            send(cmds[c][8:6], cmds[c][5:3], cmds[c][2:0], 16'hBEEF);
            checks++;
            if ({obs_lat, obs_err, obs_nw, obs_stray} !== {32'd1, 1'b1, 32'd0, 1'b0} ||
                rf_snap() !== ref_snap()) begin
                errors++; $display("FAIL illegal_%0d: got lat=%0d err=%b writes=%0d stray=%b want 1 1 0 0",
                                   c, obs_lat, obs_err, obs_nw, obs_stray);
            end
        end
    endtask

    task automatic test_reset_mid_swap();
        int t;
        model(3'd0, 3'd0, 3'd0, 16'hC001); send(3'd0, 3'd0, 3'd0, 16'hC001);
        model(3'd0, 3'd1, 3'd0, 16'hD00D); send(3'd0, 3'd1, 3'd0, 16'hD00D);
        @(negedge clk);
        CmdValid = 1'b1; CmdOp = 3'd5; CmdDst = 3'd0; CmdSrc = 3'd1;
        t = 0;
        while (!CmdReady && t < 20) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 CmdValid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        ref_rf[T] = ref_rf[0];
        exp_count = '0;
        #1;
        checks++;
        if ({RegSel, ScrSel, Done} !== {8'hFF, 1'b0}) begin
            errors++; $display("FAIL reset_mid_swap_en: got %h %h done=%b want f f 0", RegSel, ScrSel, Done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({CmdReady, Done, Err} !== 3'b100) begin
            errors++; $display("FAIL reset_mid_swap_idle: got rdy=%b done=%b err=%b want 1 0 0", CmdReady, Done, Err);
        end
        checks++;
        if (rf_snap() !== ref_snap()) begin
            errors++; $display("FAIL reset_mid_swap_regs: got %h want %h", rf_snap(), ref_snap());
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] d [5];
        logic [2:0] s [5];
        int acc_c [5];
        int acc, c, dones, overlap, bad_gap;
        for (int i = 0; i < 5; i++) begin
            d[i] = 3'($urandom_range(0, 7)); s[i] = 3'($urandom_range(0, 7)); acc_c[i] = 0;
        end
        acc = 0; c = 0; dones = 0; overlap = 0; bad_gap = 0;
        @(negedge clk);
        CmdValid = 1'b1; CmdOp = 3'd1; CmdDst = d[0]; CmdSrc = s[0]; CmdImm = '0;
        while (c < 80 && (acc < 5 || c < acc_c[4] + 4)) begin
            if (Done) dones++;
            if (CmdReady && (Done || RegSel != 4'hF || ScrSel != 4'hF)) overlap++;
            if (CmdReady && CmdValid && acc < 5) begin
                acc_c[acc] = c;
                model(3'd1, d[acc], s[acc], 16'h0);
                acc++;
                @(posedge clk);
                #1;
                if (acc < 5) begin CmdDst = d[acc]; CmdSrc = s[acc]; end
                else CmdValid = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        CmdValid = 1'b0;
        for (int i = 1; i < 5; i++) if (acc_c[i] - acc_c[i-1] != 3) bad_gap++;
        checks++;
        if (acc !== 5 || dones !== 5) begin
            errors++; $display("FAIL b2b_accepts: got accepts=%0d dones=%0d want 5 5", acc, dones);
        end
        checks++;
        if (bad_gap !== 0 || overlap !== 0) begin
            errors++; $display("FAIL b2b_spacing: got bad_gaps=%0d busy_ready=%0d want 0 0", bad_gap, overlap);
        end
        checks++;
        if (rf_snap() !== ref_snap()) begin
            errors++; $display("FAIL b2b_regs: got %h want %h", rf_snap(), ref_snap());
        end
        checks++;
`ifdef RF_SEQ_CMDCOUNT_EN
        if (CmdCount !== 16'd5) begin
            errors++; $display("FAIL b2b_count: got %0d want 5", CmdCount);
        end
`else
        if (CmdCount !== 16'd0) begin
            errors++; $display("FAIL b2b_count: got %0d want 0", CmdCount);
        end
`endif
    endtask

    task automatic test_random();
        logic [2:0]  op, d, s;
        logic [15:0] imm;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7)); d = 3'($urandom_range(0, 7));
            s = 3'($urandom_range(0, 7));  imm = 16'($urandom);
            model(op, d, s, imm);
            send(op, d, s, imm);
            checks++;
            if ({obs_nw, obs_tr, obs_lat, obs_err, obs_stray, obs_outb} !==
                {exp_nw, exp_tr, exp_lat, exp_err, 1'b0, s}) begin
                errors++; $display("FAIL rand_%0d_ctrl: op=%0d d=%0d s=%0d got %0d/%h lat=%0d err=%b stray=%b outb=%0d want %0d/%h lat=%0d err=%b",
                                   n, op, d, s, obs_nw, obs_tr, obs_lat, obs_err, obs_stray, obs_outb,
                                   exp_nw, exp_tr, exp_lat, exp_err);
            end
            checks++;
            if (rf_snap() !== ref_snap()) begin
                errors++; $display("FAIL rand_%0d_regs: got %h want %h", n, rf_snap(), ref_snap());
            end
        end
        @(negedge clk);
        checks++;
`ifdef RF_SEQ_CMDCOUNT_EN
        if (CmdCount !== exp_count) begin
            errors++; $display("FAIL rand_count: got %0d want %0d", CmdCount, exp_count);
        end
`else
        if (CmdCount !== 16'd0) begin
            errors++; $display("FAIL rand_count: got %0d want 0", CmdCount);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_inc_wrap();
        test_swap();
        test_illegal();
        test_reset_mid_swap();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
